serial_frame_tx: RTL
====================

# serial_frame_tx

Serial frame transmitter for the single-wire serial link. It takes a parallel request (port address, payload length, payload word) and serialises it as one frame: the start flag `0111110`, then the address field, then the length field, then the payload bits. It sits upstream of the link's serial receiver/sequence detector and drives the line that the receiver samples. The line idles high, so an idle line never resembles a flag.

## Interface
Parameters:
- `ADDR_W`, 2: width of the port-address field.
- `LEN_W`, 5: width of the length field.
- `DATA_W`, 16: width of the payload register; maximum payload bits per frame.
- `GAP`, 1: number of idle-high cycles forced after each frame (minimum 1).

Ports:
- `clk`  input  1  clock; all state changes on the rising edge.
- `rst`  input  1  reset, asynchronous, active-low (0 = reset).
- `start`  input  1  request a frame; sampled only while `ready`=1.
- `addr`  input  ADDR_W  port address; captured with `start`.
- `len`  input  LEN_W  payload bit count L; captured with `start`.
- `data`  input  DATA_W  payload; bits `data[L-1:0]` are sent; captured with `start`.
- `ready`  output  1  high in IDLE only; accepts `start`.
- `serOut`  output  1  registered serial line; idles at 1.
- `serValid`  output  1  registered; high on every cycle `serOut` carries a frame bit.
- `busy`  output  1  high from the cycle after acceptance until GAP completes.
- `done`  output  1  one-cycle pulse after the last frame bit.
- `err`  output  1  one-cycle pulse when a request is rejected.

## Operation
- States: IDLE, FLAG, ADDR, LEN, DATA, GAP.
- One bit index counter, sized for the largest field, plus captured `addr`/`len`/`data` registers.
- IDLE:
  - If `start`=1 and `len`≤DATA_W: capture the inputs and go to FLAG.
  - If `start`=1 and `len`>DATA_W: stay in IDLE, pulse `err` next cycle, capture nothing.
- FLAG: 7 cycles emitting `0,1,1,1,1,1,0` in that order, then ADDR.
- ADDR: ADDR_W cycles emitting the captured address, MSB first, then LEN.
- LEN: LEN_W cycles emitting the captured L, MSB first. Go to DATA if L>0, otherwise to GAP.
- DATA: L cycles emitting `data[L-1]` down to `data[0]`, then GAP.
- GAP: GAP cycles with `serOut`=1 and `serValid`=0. `done` pulses on the first GAP cycle. Return to IDLE at the end.
- No bit stuffing. The receiver counts fixed field lengths, so flag-like patterns in the address, length or payload fields are legal.
- `start` while not in IDLE is ignored. It does not queue and does not raise `err`.
- Input changes after acceptance have no effect on the frame in flight.

## Timing
- Reset values (asynchronous, immediate on `rst`=0): state IDLE, `serOut`=1, `serValid`=0, `busy`=0, `done`=0, `err`=0, `ready`=1.
- Reset mid-frame aborts the frame immediately: the line goes high and no `done` pulse is issued.
- Acceptance edge T (IDLE, `start`=1): the first flag bit appears on `serOut` in cycle T+1, with `serValid`=1 and `busy`=1.
- Frame length is F = 7 + ADDR_W + LEN_W + L bits, occupying cycles T+1 … T+F.
- `done`=1 in cycle T+F+1; `serValid`=0 from T+F+1 on.
- `ready`=1 again in cycle T+F+GAP+1. The earliest next acceptance is at that edge, so frames are separated by exactly GAP idle-high bits.
- `err` is asserted in the cycle after the rejected `start` edge; `ready` stays 1 throughout.
- `ready` is a decode of the current state. All other outputs are registered.

## Test plan
- Reset: hold `rst`=0 for 3 cycles, then release → `serOut`=1, `serValid`=0, `busy`=0, `done`=0, `err`=0, `ready`=1.
- Basic frame (defaults): `addr`=2'b10, `len`=3, `data`=16'h0005.
  - Serial bits from T+1: `0111110 10 00011 101` (17 bits) with `serValid`=1.
  - `done` at T+18; `ready` at T+19.
- Zero length: `len`=0, `addr`=2'b01 → 14 bits `0111110 01 00000`, `done` at T+15, no payload bits.
- Rejection: `len`=17 → `err` pulses one cycle, `serOut` stays 1, `busy` stays 0.
  - Then `len`=16, `data`=16'hA5C3 → 30-bit frame with payload `1010010111000011`.
- Ignored start: pulse `start` with different inputs mid-payload → frame unchanged, no `err`.
  - Hold `start`=1 continuously → next flag begins exactly 1 idle bit after the previous frame.
- Abort: assert `rst`=0 during the ADDR field → `serOut`=1 and `serValid`=0 asynchronously, no `done`.
  - After release, a new frame transmits correctly from its first flag bit.

Source files
------------

// File: rtl/serial_frame_tx.sv
// Serialises {flag 0111110, addr, len, data[len-1:0]} MSB first onto an idle-high line.
// First bit one cycle after an accepted start; start is taken only while ready (IDLE), never queued.
module serial_frame_tx #(
  parameter int ADDR_W = 2,
  parameter int LEN_W  = 5,
  parameter int DATA_W = 16,
  parameter int GAP    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] data,
  output logic              ready,
  output logic              serOut,
  output logic              serValid,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int FLAG_LEN = 7;
  localparam int GAP_CYC  = (GAP < 1) ? 1 : GAP;
  localparam int MAX_A    = (FLAG_LEN > ADDR_W) ? FLAG_LEN : ADDR_W;
  localparam int MAX_B    = (LEN_W > DATA_W) ? LEN_W : DATA_W;
  localparam int MAX_C    = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_F    = (MAX_C > GAP_CYC) ? MAX_C : GAP_CYC;
  localparam int CNT_W    = $clog2(MAX_F + 1);

  localparam logic [FLAG_LEN-1:0] FLAG_PAT = 7'b0111110;
  localparam logic [FLAG_LEN-1:0] FLAG_ONE = FLAG_LEN'(1);
  localparam logic [ADDR_W-1:0]   ADDR_ONE = ADDR_W'(1);
  localparam logic [LEN_W-1:0]    LEN_ONE  = LEN_W'(1);
  localparam logic [DATA_W-1:0]   DATA_ONE = DATA_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLAG,
    S_ADDR,
    S_LEN,
    S_DATA,
    S_GAP
  } state_t;

  state_t            state;
  state_t            nextState;
  logic [CNT_W-1:0]  idx;
  logic [CNT_W-1:0]  nextIdx;
  logic [CNT_W-1:0]  lastIdx;
  logic [CNT_W-1:0]  sel;
  logic [ADDR_W-1:0] addrQ;
  logic [LEN_W-1:0]  lenQ;
  logic [DATA_W-1:0] dataQ;

  logic lenOk;
  logic accept;
  logic reject;
  logic serOutD;
  logic serValidD;
  logic busyD;
  logic doneD;

  assign lenOk  = (int'(len) <= DATA_W);
  assign accept = (state == S_IDLE) && start && lenOk;
  assign reject = (state == S_IDLE) && start && !lenOk;
  assign ready  = (state == S_IDLE);

  // Index of the final cycle spent in the current state.
  always_comb begin
    lastIdx = '0;
    case (state)
      S_FLAG:  lastIdx = CNT_W'(FLAG_LEN - 1);
      S_ADDR:  lastIdx = CNT_W'(ADDR_W - 1);
      S_LEN:   lastIdx = CNT_W'(LEN_W - 1);
      S_DATA:  lastIdx = CNT_W'(lenQ) - CNT_W'(1);
      S_GAP:   lastIdx = CNT_W'(GAP_CYC - 1);
      default: lastIdx = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      idx   <= '0;
    end else begin
      state <= nextState;
      idx   <= nextIdx;
    end
  end

  always_comb begin
    nextState = state;
    nextIdx   = idx;
    case (state)
      S_IDLE: begin
        if (accept) begin
          nextState = S_FLAG;
          nextIdx   = '0;
        end
      end
      default: begin
        if (idx == lastIdx) begin
          nextIdx = '0;
          case (state)
            S_FLAG:  nextState = S_ADDR;
            S_ADDR:  nextState = S_LEN;
            S_LEN:   nextState = (lenQ != '0) ? S_DATA : S_GAP;
            S_DATA:  nextState = S_GAP;
            default: nextState = S_IDLE;
          endcase
        end else begin
          nextIdx = idx + CNT_W'(1);
        end
      end
    endcase
  end

  // Line bit for the cycle that follows the edge; fields are captured before they are reached.
  always_comb begin
    sel       = '0;
    serOutD   = 1'b1;
    serValidD = 1'b0;
    busyD     = (nextState != S_IDLE);
    doneD     = (nextState == S_GAP) && (state != S_GAP);
    case (nextState)
      S_FLAG: begin
        sel       = CNT_W'(FLAG_LEN - 1) - nextIdx;
        serOutD   = |(FLAG_PAT & (FLAG_ONE << sel));
        serValidD = 1'b1;
      end
      S_ADDR: begin
        sel       = CNT_W'(ADDR_W - 1) - nextIdx;
        serOutD   = |(addrQ & (ADDR_ONE << sel));
        serValidD = 1'b1;
      end
      S_LEN: begin
        sel       = CNT_W'(LEN_W - 1) - nextIdx;
        serOutD   = |(lenQ & (LEN_ONE << sel));
        serValidD = 1'b1;
      end
      S_DATA: begin
        sel       = CNT_W'(lenQ) - CNT_W'(1) - nextIdx;
        serOutD   = |(dataQ & (DATA_ONE << sel));
        serValidD = 1'b1;
      end
      default: begin
        sel       = '0;
        serOutD   = 1'b1;
        serValidD = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addrQ <= '0;
      lenQ  <= '0;
      dataQ <= '0;
    end else if (accept) begin
      addrQ <= addr;
      lenQ  <= len;
      dataQ <= data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      serOut   <= 1'b1;
      serValid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      serOut   <= serOutD;
      serValid <= serValidD;
      busy     <= busyD;
      done     <= doneD;
      err      <= reject;
    end
  end

endmodule
